// File: rtl/act_nz_scanner.sv
// act_nz_scanner: walks the non-zero entries of the input-activation register
// file in ascending address order. For each one it issues a read and streams
// the (address, value) pair over a valid/ready interface. Zero entries are
// skipped.
// Optional feature: define ACT_SCAN_STAT_EN to add the nz_count output, which
// counts the pairs accepted downstream during the current scan.
module act_nz_scanner #(
   parameter int ACT_NO     = 64,
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ACT_NO-1:0]     act_zeros,
   output logic                  act_read_en,
   output logic [ADDR_WIDTH-1:0] act_read_addr,
   input  logic [DATA_WIDTH-1:0] act_read_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
`ifdef ACT_SCAN_STAT_EN
   output logic [ADDR_WIDTH:0]   nz_count,
`endif
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t                state;
   logic [ACT_NO-1:0]     mask;          // 1 = entry already issued or zero
   logic                  inflight;      // a read was issued last cycle
   logic [ADDR_WIDTH-1:0] inflight_addr;

   // Two-entry output FIFO. The entry currently in flight is treated as an
   // extra head candidate: its data arrives from the register file this cycle
   // and is passed straight through when the FIFO is empty, so a pair is
   // presented in the same cycle its read data returns.
   logic [ADDR_WIDTH-1:0] fifo_addr [2];
   logic [DATA_WIDTH-1:0] fifo_data [2];
   logic                  wr_ptr, rd_ptr;
   logic [1:0]            fifo_count;

   logic                  any_pending;
   logic [ADDR_WIDTH-1:0] sel_idx;
   logic                  fifo_has;
   logic                  pop, pop_fifo, pop_bypass, push;
   logic [1:0]            occ, occ_after;
   logic                  issue, scan_end;

   // Priority encoder: lowest index whose mask bit is still clear.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      sel_idx = '0;
      for (int i = ACT_NO - 1; i >= 0; i--) begin
         if (!mask[i]) sel_idx = ADDR_WIDTH'(i);
      end
   end

   // Head selection, handshake, issue and completion decisions.
   always_comb begin
      any_pending = ~(&mask);
      fifo_has    = (fifo_count != 2'd0);
      out_valid   = fifo_has | inflight;
      out_addr    = '0;
      out_data    = '0;
      if (fifo_has) begin
         out_addr = fifo_addr[rd_ptr];
         out_data = fifo_data[rd_ptr];
      end else if (inflight) begin
         out_addr = inflight_addr;
         out_data = act_read_data;
      end
      pop        = out_valid & out_ready;
      pop_fifo   = pop & fifo_has;
      pop_bypass = pop & ~fifo_has;
      push       = inflight & ~pop_bypass;
      // Pairs owed downstream (queued plus in flight) after this cycle's pop.
      occ        = fifo_count + {1'b0, inflight};
      occ_after  = occ - {1'b0, pop};
      issue      = (state == S_SCAN) & any_pending & (occ_after < 2'd2);
      scan_end   = (state == S_SCAN) & ~any_pending & (occ_after == 2'd0);
      act_read_en   = issue;
      act_read_addr = issue ? sel_idx : '0;
   end

   // Control state: FSM, snapshot mask, in-flight tracking, FIFO pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
         state         <= S_IDLE;
         mask          <= '1;
         inflight      <= 1'b0;
         inflight_addr <= '0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         fifo_count    <= 2'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  mask  <= act_zeros;
                  state <= S_SCAN;
                  busy  <= 1'b1;
               end
            end
            S_SCAN: begin
               if (issue) mask[sel_idx] <= 1'b1;
               if (scan_end) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
         inflight <= issue;
         if (issue) inflight_addr <= sel_idx;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop_fifo) rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop_fifo};
      end
   end

   // FIFO storage captures the returning read data with its delayed address.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; fifo_count gates every use of it.
      if (push) begin
         fifo_addr[wr_ptr] <= inflight_addr;
         fifo_data[wr_ptr] <= act_read_data;
      end
   end

`ifdef ACT_SCAN_STAT_EN
   // Accepted-pair counter; cleared on an accepted start, held after DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         nz_count <= '0;
      end else if (state == S_IDLE && start) begin
         nz_count <= '0;
      end else if (state == S_SCAN && pop) begin
         nz_count <= nz_count + 1'b1;
      end
   end
`endif

endmodule

// File: doc/act_nz_scanner.md
Name: act_nz_scanner

Overview:
- Sits directly downstream of the PE's activation register-file pair, on the input-activation side.
- Snapshots the input-activation zero flags and walks the non-zero entries in ascending address order.
- For each non-zero entry it issues a read to the register file and streams an (address, value) pair over a valid/ready interface to the PE MAC/broadcast stage.
- Zero activations are skipped entirely; this is the block that exploits activation sparsity.

Parameters:
ACT_NO, 64, number of activation entries (matches PE_ACT_NO)
ADDR_WIDTH, 6, activation address width, clog2(ACT_NO)
DATA_WIDTH, 16, activation data width (matches PE_DATA_WIDTH)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
start  input  1  single-cycle pulse: begin a scan; ignored unless idle
act_zeros  input  ACT_NO  per-entry zero flags from the activation register file (1 = entry is zero)
act_read_en  output  1  register-file read enable
act_read_addr  output  ADDR_WIDTH  register-file read address
act_read_data  input  DATA_WIDTH  register-file read data, valid the cycle after act_read_en
out_valid  output  1  output pair valid
out_ready  input  1  downstream accepts the pair when out_valid & out_ready
out_addr  output  ADDR_WIDTH  activation index of the output pair
out_data  output  DATA_WIDTH  activation value of the output pair
busy  output  1  high from the cycle after an accepted start until done
done  output  1  single-cycle pulse: scan complete and all pairs consumed

Behaviour:
- Clocking and reset: single clock domain. On rst, every register clears in the same edge: state=IDLE, mask all ones, FIFO empty, in-flight flag 0. Outputs are then act_read_en=0, act_read_addr=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0.
- States:
  - IDLE: waits for start.
  - SCAN: issues reads and drains.
  - DONE: lasts one cycle, then returns to IDLE.
- Start:
  - In IDLE, start at cycle T latches mask <= act_zeros and moves to SCAN at T+1.
  - start outside IDLE is ignored.
  - Later changes on act_zeros do not affect the scan in progress.
- Selection: a priority encoder picks the lowest index i whose mask bit is 0. An issue drives act_read_en=1 and act_read_addr=i, and sets mask[i]=1 on the same edge.
- Read latency: one cycle. act_read_data is captured together with the delayed address into a 2-entry output FIFO. FIFO head drives out_valid, out_addr and out_data.
- Issue rule (SCAN only): issue when a zero mask bit remains and (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready.
  - This sustains one pair per cycle while out_ready is held high.
  - The FIFO never overflows.
- Backpressure: out_addr and out_data stay stable while out_valid=1 and out_ready=0.
- Completion:
  - When mask is all ones, inflight=0 and the FIFO will be empty after this cycle's pop, the next state is DONE.
  - done=1 for exactly one cycle in DONE; busy=0 in DONE.
  - An all-zero snapshot gives done at T+2 with no reads issued.
- Ordering: output addresses are strictly increasing within a scan. Each non-zero entry is emitted exactly once.
- Value check: a value that reads back as 0 despite its flag being 0 is still emitted; the block does not re-check values.
- Reset mid-scan: everything is flushed, no done pulse, out_valid drops on the next edge.
- start coincident with rst: rst wins.

Optional Feature:
- Macro: ACT_SCAN_STAT_EN.
- When defined:
  - Adds output port nz_count [ADDR_WIDTH:0].
  - It counts pairs accepted downstream during the current scan and clears on an accepted start.
  - It holds its final value from DONE until the next accepted start; reset value 0.
- When undefined: the port and counter are absent, with no other behavioural difference.

Test Plan:
- All non-zero, out_ready=1: act_zeros=64'h0, start at T -> act_read_en high T+1..T+64; out_addr 0..63 on consecutive cycles T+2..T+65; done at T+66.
- Sparse pattern: act_zeros=~64'h8000_0000_0000_0011, data = index+100 -> exactly three pairs (0,100), (4,104), (63,163) in order, then done; nz_count=3 with ACT_SCAN_STAT_EN.
- All zero: act_zeros=64'hFFFF_FFFF_FFFF_FFFF, start at T -> no act_read_en, out_valid never high, done at T+2, busy high only at T+1.
- Backpressure: 8 non-zero entries with out_ready toggling 1,0,0,1 repeating -> no lost or duplicated pairs; out_addr/out_data stable while stalled; at most 2 reads ahead of consumption.
- Snapshot/start-ignore: change act_zeros and pulse start mid-scan -> emitted set matches the original snapshot; no restart.
- Reset mid-scan: assert rst after 5 pairs -> next cycle out_valid=0, busy=0, no done pulse; a fresh start rescans from index 0.
